// File: rtl/comm_pkg.sv
// Shared definitions for the end-of-game frame path: FSM encoding, protocol
// byte constants and frame geometry helpers.
package comm_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_BUILD     = 2'd1,
    S_LOAD      = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  localparam logic [7:0] TRIGGER_EVT = 8'hAB;
  localparam logic [7:0] EVENT_EVT   = 8'hAE;
  localparam logic [7:0] RESULT_WIN  = 8'h10;
  localparam logic [7:0] RESULT_LOSS = 8'h00;

  function automatic int unsigned score_bytes(input int unsigned score_w);
    return (score_w + 32'd7) / 32'd8;
  endfunction

  // Event code + result byte, then optional big-endian score and checksum.
  function automatic int unsigned frame_len(input int unsigned score_w,
                                            input int unsigned send_score,
                                            input int unsigned checksum_en);
    return 32'd2 + send_score * score_bytes(score_w) + checksum_en;
  endfunction

endpackage

// File: rtl/end_game_frame_tx_if.sv
// UART byte handshake between the frame transmitter (master) and the UART
// transmitter (slave).
interface end_game_frame_tx_if;
  logic [7:0] tx_data;
  logic       send;
  logic       tx_busy;
  logic       data_sent;

  modport master (output tx_data, output send, input tx_busy, input data_sent);
  modport slave  (input tx_data, input send, output tx_busy, output data_sent);
endinterface

// File: rtl/end_game_frame_builder.sv
// Combinational byte selector: maps a frame index to the event code, result
// byte, big-endian score bytes or running checksum.
module end_game_frame_builder
  import comm_pkg::*;
#(
  parameter logic [7:0] EVENT_CODE = EVENT_EVT,
  parameter int         SCORE_W    = 5,
  parameter logic [7:0] WIN_BYTE   = RESULT_WIN,
  parameter logic [7:0] LOSS_BYTE  = RESULT_LOSS,
  parameter int         SEND_SCORE = 0
) (
  input  logic [2:0]         index,
  input  logic [SCORE_W-1:0] score,
  input  logic               vitoria,
  input  logic [7:0]         acc,
  output logic [7:0]         frame_byte
);

  localparam int unsigned SB = score_bytes(SCORE_W);
  localparam logic [2:0] SCORE_END = 3'(2 + SB);

  logic [15:0] score_ext;
  assign score_ext = 16'(score);

  // Any index past the score bytes is the checksum slot.
  always_comb begin
    frame_byte = acc;
    if (index == 3'd0) begin
      frame_byte = EVENT_CODE;
    end else if (index == 3'd1) begin
      frame_byte = vitoria ? WIN_BYTE : LOSS_BYTE;
    end else if ((SEND_SCORE != 0) && (index < SCORE_END)) begin
      if ((SB == 2) && (index == 3'd2)) begin
        frame_byte = score_ext[15:8];
      end else begin
        frame_byte = score_ext[7:0];
      end
    end
  end

endmodule

// File: rtl/end_game_frame_tx.sv
// End-of-game frame transmitter: waits for the payload builder, snapshots the
// score and serialises the frame one byte per UART handshake.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   IDLE      | waiting for a qualified trigger event
//   BUILD     | build_payload high, waiting for payload_ready or timeout
//   LOAD      | present byte[idx] and strobe send once UART is free
//   WAIT_DONE | waiting for data_sent for the byte just loaded
module end_game_frame_tx
  import comm_pkg::*;
#(
  parameter logic [7:0] EVENT_CODE     = EVENT_EVT,
  parameter logic [7:0] TRIGGER_CODE   = TRIGGER_EVT,
  parameter int         SCORE_W        = 5,
  parameter int         WIN_THRESHOLD  = 20,
  parameter logic [7:0] WIN_BYTE       = RESULT_WIN,
  parameter logic [7:0] LOSS_BYTE      = RESULT_LOSS,
  parameter int         SEND_SCORE     = 0,
  parameter int         CHECKSUM_EN    = 0,
  parameter int         TIMEOUT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  end_game_frame_tx_if.master       tx,
  input  logic                      block,
  input  logic                      data_valid,
  input  logic [7:0]                evento,
  input  logic                      payload_ready,
  input  logic [SCORE_W-1:0]        pontuacao,
  output logic                      build_payload,
  output logic                      fim_jogo,
  output logic                      vitoria,
  output logic                      timeout,
  output logic                      busy
);

  localparam logic [1:0] IDLE      = S_IDLE;
  localparam logic [1:0] BUILD     = S_BUILD;
  localparam logic [1:0] LOAD      = S_LOAD;
  localparam logic [1:0] WAIT_DONE = S_WAIT_DONE;

  localparam int unsigned FRAME_LEN = frame_len(SCORE_W, SEND_SCORE, CHECKSUM_EN);
  localparam logic [2:0]  LAST_IDX  = 3'(FRAME_LEN - 1);
  localparam logic [31:0] WIN_TH    = 32'(WIN_THRESHOLD);

  // Down-counter loaded with TIMEOUT_CYCLES-1 so terminal count (zero) lands
  // on the last allowed BUILD cycle.
  localparam int               TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0]  TO_LOAD = (TIMEOUT_CYCLES > 1) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);

  logic [1:0]         state;
  logic [2:0]         idx;
  logic [SCORE_W-1:0] score_q;
  logic [7:0]         acc;
  logic [7:0]         frame_byte;
  logic [TO_W-1:0]    to_cnt;
  logic               trigger;
  logic               win;

  assign trigger = data_valid && !block && (evento == TRIGGER_CODE);
  assign win     = (32'(pontuacao) >= WIN_TH);

  end_game_frame_builder #(
    .EVENT_CODE (EVENT_CODE),
    .SCORE_W    (SCORE_W),
    .WIN_BYTE   (WIN_BYTE),
    .LOSS_BYTE  (LOSS_BYTE),
    .SEND_SCORE (SEND_SCORE)
  ) u_builder (
    .index      (idx),
    .score      (score_q),
    .vitoria    (vitoria),
    .acc        (acc),
    .frame_byte (frame_byte)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      idx           <= '0;
      score_q       <= '0;
      acc           <= '0;
      to_cnt        <= '0;
      tx.tx_data    <= '0;
      tx.send       <= 1'b0;
      build_payload <= 1'b0;
      fim_jogo      <= 1'b0;
      vitoria       <= 1'b0;
      timeout       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      tx.send  <= 1'b0;
      fim_jogo <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            state         <= BUILD;
            build_payload <= 1'b1;
            busy          <= 1'b1;
            to_cnt        <= TO_LOAD;
          end
        end
        BUILD: begin
          if (payload_ready) begin
            score_q       <= pontuacao;
            vitoria       <= win;
            idx           <= '0;
            acc           <= '0;
            build_payload <= 1'b0;
            state         <= LOAD;
          end else if (TO_EN && (to_cnt == '0)) begin
            timeout       <= 1'b1;
            build_payload <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end else if (TO_EN) begin
            to_cnt <= to_cnt - TO_W'(1);
          end
        end
        LOAD: begin
          if (!tx.tx_busy) begin
            tx.tx_data <= frame_byte;
            tx.send    <= 1'b1;
            acc        <= acc ^ frame_byte;
            state      <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tx.data_sent) begin
            if (idx == LAST_IDX) begin
              fim_jogo <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              idx   <= idx + 3'd1;
              state <= LOAD;
            end
          end
        end
        default: begin
          state         <= IDLE;
          build_payload <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule
